// File: rtl/conv_3_acc_round_sat.sv
// conv_3 accumulator: sums KERNEL_LEN signed products per window on top of a
// bias seed. The sum is rounded half up, arithmetic-shifted by SHIFT and
// saturated to OUT_WIDTH. Both sides use a valid/ready handshake, and the
// result is held in a single output register.
// Optional feature macro: CONV_3_ACC_RELU_EN. When it is defined, negative
// saturated results are forced to zero.
module conv_3_acc_round_sat #(
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned KERNEL_LEN = 9,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [OUT_WIDTH-1:0] bias,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag,
  output logic                 busy
);

  localparam int unsigned CNT_WIDTH = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int unsigned RND_WIDTH = ACC_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(KERNEL_LEN - 1);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [RND_WIDTH-1:0] RND_MAX = RND_WIDTH'(OUT_MAX);
  localparam logic signed [RND_WIDTH-1:0] RND_MIN = RND_WIDTH'(OUT_MIN);
  localparam logic signed [RND_WIDTH-1:0] RND_HALF = RND_WIDTH'(1) <<< (SHIFT - 1);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    RES  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                        state, state_nxt;
  logic [CNT_WIDTH-1:0]          cnt, cnt_nxt;
  logic signed [ACC_WIDTH-1:0]   acc, acc_nxt;
  logic [OUT_WIDTH-1:0]          out_data_nxt;
  logic                          out_valid_nxt;
  logic                          sat_flag_nxt;
  logic                          in_ready_nxt;
  logic                          busy_nxt;

  logic signed [ACC_WIDTH-1:0]   data_ext;
  logic signed [ACC_WIDTH-1:0]   bias_seed;
  logic signed [RND_WIDTH-1:0]   rnd_sum;
  logic signed [RND_WIDTH-1:0]   r_full;
  logic                          sat_hi;
  logic                          sat_lo;
  logic signed [OUT_WIDTH-1:0]   sat_val;
  logic signed [OUT_WIDTH-1:0]   res_val;

  // Operand extension, rounding, and clamping of the finished accumulator.
  // The rounding sum is one bit wider than the accumulator, so adding the
  // half-LSB constant cannot wrap.
  always_comb begin
    data_ext  = ACC_WIDTH'($signed(in_data));
    bias_seed = ACC_WIDTH'($signed(bias)) <<< SHIFT;
    rnd_sum   = RND_WIDTH'(acc) + RND_HALF;
    r_full    = rnd_sum >>> SHIFT;
    sat_hi    = (r_full > RND_MAX);
    sat_lo    = (r_full < RND_MIN);
    if (sat_hi) begin
      sat_val = OUT_MAX;
    end else if (sat_lo) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = OUT_WIDTH'(r_full);
    end
`ifdef CONV_3_ACC_RELU_EN
    res_val = sat_val[OUT_WIDTH-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  // Next-state logic and next values for all registers.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    sat_flag_nxt  = sat_flag;
    case (state)
      ACC: begin
        if (in_valid) begin
          acc_nxt = ((cnt == '0) ? bias_seed : acc) + data_ext;
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = RES;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
      end
      RES: begin
        out_data_nxt  = res_val;
        out_valid_nxt = 1'b1;
        if (sat_hi || sat_lo) begin
          sat_flag_nxt = 1'b1;
        end
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = ACC;
        end
      end
      default: begin
        state_nxt = ACC;
      end
    endcase
    in_ready_nxt = (state_nxt == ACC);
    busy_nxt     = (cnt_nxt != '0) || (state_nxt != ACC);
  end

  // State and output registers. A reset discards any partial window.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= ACC;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      sat_flag  <= sat_flag_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_conv_3_acc_round_sat.sv
// Directed, table-driven bench for conv_3_acc_round_sat with default
// parameters, plus hand-written sequences for latency, backpressure, bias
// sampling, and reset in the middle of a window.
module tb_conv_3_acc_round_sat;

`ifdef CONV_3_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic signed [15:0] bias;
  logic signed [23:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sat_flag;
  logic               busy;

  int checks = 0;
  int errors = 0;

  conv_3_acc_round_sat dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .bias      (bias),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    bit                 rst_before;
    logic signed [15:0] b;
    logic signed [23:0] first;
    logic signed [23:0] rest;
    int                 exp_out;
    bit                 exp_sat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu_model(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  task automatic do_reset();
    @(negedge ap_clk);
    in_valid = 1'b0;
    ap_rst   = 1'b1;
    @(negedge ap_clk);
    ap_rst   = 1'b0;
  endtask

  // Present one product and return just after the edge that accepts it.
  task automatic push(input logic signed [23:0] d, input logic signed [15:0] b);
    int guard;
    guard = 0;
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = d;
    bias     = b;
    while (!in_ready && guard < 50) begin
      @(negedge ap_clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready got 0 expected 1");
    end
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for a result, sample it, and let it transfer (out_ready is high).
  task automatic get_result(output logic signed [15:0] d, output logic s);
    int guard;
    guard = 0;
    @(negedge ap_clk);
    while (!out_valid && guard < 50) begin
      @(negedge ap_clk);
      guard++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid got 0 expected 1");
    end
    d = out_data;
    s = sat_flag;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    logic signed [15:0] rd;
    logic               rs;

    vecs[0]  = '{1'b0,  16'sd0,  24'sd256,      24'sd256,      9,      1'b0};
    vecs[1]  = '{1'b0,  16'sd0,  24'sd384,      24'sd0,        2,      1'b0};
    vecs[2]  = '{1'b0,  16'sd0, -24'sd384,      24'sd0,       -1,      1'b0};
    vecs[3]  = '{1'b0,  16'sd0,  24'sd127,      24'sd0,        0,      1'b0};
    vecs[4]  = '{1'b0,  16'sd0, -24'sd128,      24'sd0,        0,      1'b0};
    vecs[5]  = '{1'b0,  16'sd0, -24'sd129,      24'sd0,       -1,      1'b0};
    vecs[6]  = '{1'b0,  16'sd5,  24'sd0,        24'sd0,        5,      1'b0};
    vecs[7]  = '{1'b0, -16'sd3,  24'sd256,      24'sd256,      6,      1'b0};
    vecs[8]  = '{1'b0,  16'sd0, -24'sd256,     -24'sd256,     -9,      1'b0};
    vecs[9]  = '{1'b0,  16'sd0,  24'sd8388607,  24'sd8388607,  32767,  1'b1};
    vecs[10] = '{1'b0,  16'sd0,  24'sd256,      24'sd256,      9,      1'b1};
    vecs[11] = '{1'b1,  16'sd0, -24'sd8388608, -24'sd8388608, -32768,  1'b1};
    vecs[12] = '{1'b1,  16'sd0,  24'sd256,      24'sd256,      9,      1'b0};

    ap_rst    = 1'b1;
    bias      = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'sd0);
    check("reset_out_data", 32'($signed(out_data)), 32'sd0);
    check("reset_sat_flag", 32'(sat_flag), 32'sd0);
    check("reset_busy", 32'(busy), 32'sd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("reset_in_ready", 32'(in_ready), 32'sd1);

    // Table-driven windows.
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rst_before) do_reset();
      push(vecs[i].first, vecs[i].b);
      for (int k = 1; k < 9; k++) push(vecs[i].rest, vecs[i].b);
      get_result(rd, rs);
      check($sformatf("vec%0d_out", i), 32'(rd), relu_model(vecs[i].exp_out));
      check($sformatf("vec%0d_sat", i), 32'(rs), 32'(vecs[i].exp_sat));
    end

    // Latency and in_ready-low window.
    do_reset();
    for (int k = 0; k < 9; k++) push(24'sd256, 16'sd0);
    check("lat_res_out_valid", 32'(out_valid), 32'sd0);
    check("lat_res_in_ready", 32'(in_ready), 32'sd0);
    check("lat_res_busy", 32'(busy), 32'sd1);
    @(posedge ap_clk);
    #1;
    check("lat_hold_out_valid", 32'(out_valid), 32'sd1);
    check("lat_hold_out_data", 32'($signed(out_data)), 32'sd9);
    check("lat_hold_in_ready", 32'(in_ready), 32'sd0);
    @(posedge ap_clk);
    #1;
    check("lat_done_out_valid", 32'(out_valid), 32'sd0);
    check("lat_done_in_ready", 32'(in_ready), 32'sd1);
    check("lat_done_busy", 32'(busy), 32'sd0);

    // Backpressure: a pending product must wait until the result transfers.
    @(negedge ap_clk);
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) push(24'sd256, 16'sd0);
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = 24'sd1000;
    bias     = 16'sd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk);
      #1;
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'sd1);
      check($sformatf("bp%0d_out_data", c), 32'($signed(out_data)), 32'sd9);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'sd0);
    end
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    check("bp_xfer_out_valid", 32'(out_valid), 32'sd0);
    check("bp_xfer_in_ready", 32'(in_ready), 32'sd1);
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
    check("bp_first_accepted_busy", 32'(busy), 32'sd1);
    for (int k = 1; k < 9; k++) push(24'sd0, 16'sd0);
    get_result(rd, rs);
    check("bp_next_window_out", 32'(rd), 32'sd4);

    // The bias is sampled only at the first accept of a window.
    push(24'sd0, 16'sd7);
    for (int k = 1; k < 9; k++) push(24'sd0, 16'sd100);
    get_result(rd, rs);
    check("bias_mid_window_out", 32'(rd), 32'sd7);

    // Reset after four products discards the partial window.
    for (int k = 0; k < 4; k++) push(24'sd256, 16'sd0);
    check("partial_busy", 32'(busy), 32'sd1);
    do_reset();
    check("partial_rst_busy", 32'(busy), 32'sd0);
    check("partial_rst_in_ready", 32'(in_ready), 32'sd1);
    for (int k = 0; k < 9; k++) push(24'sd256, 16'sd0);
    get_result(rd, rs);
    check("after_partial_out", 32'(rd), 32'sd9);
    check("after_partial_sat", 32'(rs), 32'sd0);
    for (int k = 0; k < 9; k++) push(-24'sd256, 16'sd0);
    get_result(rd, rs);
    check("relu_neg_out", 32'(rd), relu_model(-9));
    check("relu_neg_sat", 32'(rs), 32'sd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time got 200000 expected less");
    $fatal(1, "timeout");
  end

endmodule
